// File: rtl/md_defs.sv
// Shared multiply/divide opcode encodings and MDU FSM state type.
// The hazard unit and controller import these as well as the MDU itself.
package md_defs;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mduStateE;

    function automatic logic isMulOp(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic isDivOp(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational HI/LO result generator for MULT/MULTU/DIV/DIVU,
// including divide-by-zero and signed-overflow corner cases.
module md_calc
    import md_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       MDOp,
    output logic [WIDTH-1:0] hiRes,
    output logic [WIDTH-1:0] loRes
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic                 isSigned;
    logic [2*WIDTH-1:0]   opA;
    logic [2*WIDTH-1:0]   opB;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     magA;
    logic [WIDTH-1:0]     magB;
    logic [WIDTH-1:0]     divisor;
    logic [WIDTH-1:0]     qMag;
    logic [WIDTH-1:0]     rMag;
    logic [WIDTH-1:0]     quot;
    logic [WIDTH-1:0]     rem;

    assign isSigned = (MDOp == MD_MULT) || (MDOp == MD_DIV);

    // Sign-extending to 2*WIDTH lets one unsigned multiplier serve both flavours.
    assign opA  = {{WIDTH{isSigned & A[WIDTH-1]}}, A};
    assign opB  = {{WIDTH{isSigned & B[WIDTH-1]}}, B};
    assign prod = opA * opB;

    // Signed division works on magnitudes, then restores truncate-toward-zero signs.
    assign magA    = (isSigned && A[WIDTH-1]) ? -A : A;
    assign magB    = (isSigned && B[WIDTH-1]) ? -B : B;
    assign divisor = (B == '0) ? WIDTH'(1) : magB;
    assign qMag    = magA / divisor;
    assign rMag    = magA % divisor;
    assign quot    = (isSigned && (A[WIDTH-1] ^ B[WIDTH-1])) ? -qMag : qMag;
    assign rem     = (isSigned && A[WIDTH-1]) ? -rMag : rMag;

    always_comb begin
        hiRes = prod[2*WIDTH-1:WIDTH];
        loRes = prod[WIDTH-1:0];
        if (isDivOp(MDOp)) begin
            if (B == '0) begin
                hiRes = A;
                loRes = '1;
            end else if (isSigned && (A == MIN_NEG) && (B == '1)) begin
                hiRes = '0;
                loRes = A;
            end else begin
                hiRes = rem;
                loRes = quot;
            end
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Multi-cycle multiply/divide unit: result computed at acceptance, held
// for a fixed latency, then committed to HI/LO unless cancelled.
module mdu_iter
    import md_defs::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       MDOp,
    input  logic             Start,
    input  logic             Cancel,
    output logic             Busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    mduStateE         state;
    mduStateE         nextState;
    logic [CW-1:0]    count;
    logic [CW-1:0]    nextCount;
    logic [WIDTH-1:0] pendHi;
    logic [WIDTH-1:0] pendLo;
    logic [WIDTH-1:0] nextPendHi;
    logic [WIDTH-1:0] nextPendLo;
    logic [WIDTH-1:0] nextHi;
    logic [WIDTH-1:0] nextLo;
    logic [WIDTH-1:0] hiRes;
    logic [WIDTH-1:0] loRes;
    logic             accept;

    md_calc #(.WIDTH(WIDTH)) calc (
        .A     (A),
        .B     (B),
        .MDOp  (MDOp),
        .hiRes (hiRes),
        .loRes (loRes)
    );

    assign Busy   = (state == RUN);
    assign accept = Start && !Cancel && (state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            pendHi <= '0;
            pendLo <= '0;
            HI     <= '0;
            LO     <= '0;
        end else begin
            state  <= nextState;
            count  <= nextCount;
            pendHi <= nextPendHi;
            pendLo <= nextPendLo;
            HI     <= nextHi;
            LO     <= nextLo;
        end
    end

    // Cancel is checked before completion so a flush always discards the result.
    always_comb begin
        nextState  = state;
        nextCount  = count;
        nextPendHi = pendHi;
        nextPendLo = pendLo;
        nextHi     = HI;
        nextLo     = LO;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (isMulOp(MDOp) || isDivOp(MDOp)) begin
                        nextState  = RUN;
                        nextCount  = isMulOp(MDOp) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                        nextPendHi = hiRes;
                        nextPendLo = loRes;
                    end else if (MDOp == MD_MTHI) begin
                        nextHi = A;
                    end else if (MDOp == MD_MTLO) begin
                        nextLo = A;
                    end
                end
            end
            RUN: begin
                if (Cancel) begin
                    nextState  = IDLE;
                    nextCount  = '0;
                    nextPendHi = '0;
                    nextPendLo = '0;
                end else if (count == CW'(1)) begin
                    nextState = IDLE;
                    nextCount = '0;
                    nextHi    = pendHi;
                    nextLo    = pendLo;
                end else begin
                    nextCount = count - CW'(1);
                end
            end
            default: begin
                nextState = IDLE;
                nextCount = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed ops with a HI/LO scoreboard,
// busy-length checks, ignored starts, cancel and asynchronous reset.
module tb_mdu_iter;
    import md_defs::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  MDOp;
    logic        Start;
    logic        Cancel;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int errors = 0;
    int checks = 0;
    logic [63:0] expQ[$];
    logic [31:0] modelHi = '0;
    logic [31:0] modelLo = '0;

    mdu_iter #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .A      (A),
        .B      (B),
        .MDOp   (MDOp),
        .Start  (Start),
        .Cancel (Cancel),
        .Busy   (Busy),
        .HI     (HI),
        .LO     (LO)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Independent reference using native int/longint arithmetic; returns {HI,LO}.
    function automatic logic [63:0] refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint unsigned ua;
        longint unsigned ub;
        int qi;
        int ri;
        case (op)
            MD_MULT: begin
                sa = longint'(int'(a));
                sb = longint'(int'(b));
                return 64'(sa * sb);
            end
            MD_MULTU: begin
                ua = 64'(a);
                ub = 64'(b);
                return 64'(ua * ub);
            end
            MD_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
                qi = int'(a) / int'(b);
                ri = int'(a) % int'(b);
                return {32'(ri), 32'(qi)};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic cancel, input logic [63:0] exp);
        MDOp   = op;
        A      = a;
        B      = b;
        Start  = 1'b1;
        Cancel = cancel;
        expQ.push_back(exp);
        {modelHi, modelLo} = exp;
        @(posedge clk);
        #1;
        Start  = 1'b0;
        Cancel = 1'b0;
    endtask

    // injectAt selects the Busy cycle in which a Cancel or a stray MULT start is driven.
    task automatic checkOutput(input string tag, input int expCycles, input int injectAt, input logic injectCancel);
        int busyCycles;
        logic heldOk;
        logic [63:0] held;
        logic [63:0] exp;
        busyCycles = 0;
        heldOk     = 1'b1;
        held       = {HI, LO};
        while (Busy === 1'b1 && busyCycles < 200) begin
            busyCycles++;
            if ({HI, LO} !== held) heldOk = 1'b0;
            if (busyCycles == injectAt) begin
                if (injectCancel) begin
                    Cancel = 1'b1;
                end else begin
                    Start = 1'b1;
                    MDOp  = MD_MULT;
                    A     = 32'd3;
                    B     = 32'd3;
                end
            end
            @(posedge clk);
            #1;
            Start  = 1'b0;
            Cancel = 1'b0;
        end
        checkVal({tag, ".busyCycles"}, 64'(busyCycles), 64'(expCycles));
        if (expCycles > 0) checkVal({tag, ".heldDuringBusy"}, 64'(heldOk), 64'd1);
        if (expQ.size() == 0) begin
            checkVal({tag, ".scoreboardEmpty"}, 64'(expQ.size()), 64'd1);
        end else begin
            exp = expQ.pop_front();
            checkVal({tag, ".hilo"}, {HI, LO}, exp);
        end
    endtask

    initial begin
        reset  = 1'b1;
        Start  = 1'b0;
        Cancel = 1'b0;
        A      = '0;
        B      = '0;
        MDOp   = '0;
        repeat (2) @(posedge clk);
        #1;
        checkVal("reset.busy", 64'(Busy), 64'd0);
        checkVal("reset.hilo", {HI, LO}, 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(MD_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFF1);
        checkOutput("multNeg", 5, 0, 1'b0);
        applyStimulus(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 64'h0000_0001_FFFF_FFFE);
        checkOutput("multu", 5, 0, 1'b0);
        applyStimulus(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD);
        checkOutput("divNeg", 10, 0, 1'b0);
        applyStimulus(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 64'h0000_0000_8000_0000);
        checkOutput("divOverflow", 10, 0, 1'b0);
        applyStimulus(MD_DIVU, 32'd7, 32'd0, 1'b0, 64'h0000_0007_FFFF_FFFF);
        checkOutput("divuByZero", 10, 0, 1'b0);
        applyStimulus(MD_DIV, 32'hFFFF_FFF9, 32'd0, 1'b0, 64'hFFFF_FFF9_FFFF_FFFF);
        checkOutput("divByZero", 10, 0, 1'b0);
        applyStimulus(MD_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, 64'h0000_0001_FFFF_FFFD);
        checkOutput("divNegDivisor", 10, 0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i == 5) ? 32'd0 : $urandom;
            applyStimulus(op, a, b, 1'b0, refModel(op, a, b));
            checkOutput("randomOp", isMulOp(op) ? 5 : 10, 0, 1'b0);
        end

        applyStimulus(MD_MTHI, 32'h0000_1234, 32'd0, 1'b0, {32'h0000_1234, modelLo});
        checkOutput("mthi", 0, 0, 1'b0);
        applyStimulus(MD_MTLO, 32'h0000_5678, 32'd0, 1'b0, {modelHi, 32'h0000_5678});
        checkOutput("mtlo", 0, 0, 1'b0);
        applyStimulus(3'd6, 32'hDEAD_BEEF, 32'd1, 1'b0, {modelHi, modelLo});
        checkOutput("reservedOp", 0, 0, 1'b0);
        applyStimulus(MD_MULT, 32'd9, 32'd9, 1'b1, {modelHi, modelLo});
        checkOutput("cancelAtIdle", 0, 0, 1'b0);

        applyStimulus(MD_DIVU, 32'd100, 32'd7, 1'b0, 64'h0000_0002_0000_000E);
        checkOutput("startWhileBusy", 10, 3, 1'b0);
        applyStimulus(MD_DIVU, 32'd50, 32'd3, 1'b1, {modelHi, modelLo});
        checkOutput("cancelAtIdleDivu", 0, 0, 1'b0);
        applyStimulus(MD_DIVU, 32'd50, 32'd3, 1'b0, {modelHi, modelLo});
        checkOutput("cancelMidOp", 4, 4, 1'b1);

        MDOp  = MD_MULT;
        A     = 32'd11;
        B     = 32'd13;
        Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        @(posedge clk);
        #2;
        checkVal("resetMid.busyBefore", 64'(Busy), 64'd1);
        reset = 1'b1;
        #1;
        checkVal("resetMid.busy", 64'(Busy), 64'd0);
        checkVal("resetMid.hilo", {HI, LO}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelHi = '0;
        modelLo = '0;
        @(posedge clk);
        #1;

        applyStimulus(MD_MULT, 32'd6, 32'd7, 1'b0, 64'd42);
        checkOutput("multAfterReset", 5, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
